// File: rtl/count_ctrl_pkg.sv
// Shared types and default constants for the command-driven mod-N counter.
package count_ctrl_pkg;

  localparam int COUNT_CW  = 4;
  localparam int COUNT_MOD = 12;
  localparam int COUNT_LW  = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/count_core.sv
// Loadable modulo-MOD up/down counter. No command awareness; load wins over en.
module count_core
  import count_ctrl_pkg::*;
#(
  parameter int CW  = COUNT_CW,
  parameter int MOD = COUNT_MOD
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] data_in,
  input  logic          up_down,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap_nxt
);

  localparam logic [CW-1:0] TOP = CW'(MOD - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: load, or step with wrap at either end of the range.
  always_comb begin
    count_d  = count_q;
    wrap_nxt = 1'b0;
    if (load) begin
      count_d = data_in;
    end else if (en) begin
      if (up_down) begin
        if (count_q == TOP) begin
          count_d  = '0;
          wrap_nxt = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d  = TOP;
          wrap_nxt = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Command sequencer around count_core: load, step len times, pulse done.
// Optional stall input enabled by defining COUNT_CTRL_PAUSE_EN.
module count_seq_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int CW  = COUNT_CW,
  parameter int MOD = COUNT_MOD,
  parameter int LW  = COUNT_LW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_load_val,
  input  logic          cmd_up_down,
  input  logic [LW-1:0] cmd_len,
`ifdef COUNT_CTRL_PAUSE_EN
  input  logic          pause,
`endif
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic          wrap
);

  localparam logic [CW:0]   MOD_W = (CW + 1)'(MOD);
  localparam logic [CW-1:0] TOP   = CW'(MOD - 1);

  ctrl_state_t   state_q, state_d;
  logic [CW-1:0] load_val_q, load_val_d;
  logic          up_down_q, up_down_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] remaining_q, remaining_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          wrap_q, wrap_d;
  logic          stall;
  logic          core_load, core_en, wrap_nxt;

`ifdef COUNT_CTRL_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign core_load = (state_q == LOAD);
  assign core_en   = (state_q == RUN) && !stall;
  assign cmd_ready = (state_q == IDLE);

  count_core #(
    .CW  (CW),
    .MOD (MOD)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .load     (core_load),
    .data_in  (load_val_q),
    .up_down  (up_down_q),
    .en       (core_en),
    .count    (count),
    .wrap_nxt (wrap_nxt)
  );

  // Next-state, command capture and remaining-step bookkeeping.
  always_comb begin
    state_d     = state_q;
    load_val_d  = load_val_q;
    up_down_d   = up_down_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          load_val_d = ({1'b0, cmd_load_val} >= MOD_W) ? TOP : cmd_load_val;
          up_down_d  = cmd_up_down;
          len_d      = cmd_len;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        remaining_d = len_q;
        state_d     = (len_q == '0) ? DONE : RUN;
      end
      RUN: begin
        if (!stall) begin
          remaining_d = remaining_q - LW'(1);
          if (remaining_q == LW'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered, so they are decoded from the next state.
    done_d = (state_d == DONE);
    busy_d = (state_d == LOAD) || (state_d == RUN);
    wrap_d = wrap_nxt;
  end

  // Control registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      load_val_q  <= '0;
      up_down_q   <= 1'b0;
      len_q       <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_val_q  <= load_val_d;
      up_down_q   <= up_down_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
    end
  end

  assign done = done_q;
  assign busy = busy_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed self-checking bench for count_seq_ctrl.
module tb_count_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_load_val = '0;
  logic       cmd_up_down = 1'b0;
  logic [7:0] cmd_len = '0;
`ifdef COUNT_CTRL_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [3:0] count;
  logic       busy, done, wrap;

  int n_tests = 0;
  int n_fail  = 0;

  count_seq_ctrl #(.CW(4), .MOD(12), .LW(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_load_val (cmd_load_val),
    .cmd_up_down  (cmd_up_down),
    .cmd_len      (cmd_len),
`ifdef COUNT_CTRL_PAUSE_EN
    .pause        (pause),
`endif
    .count        (count),
    .busy         (busy),
    .done         (done),
    .wrap         (wrap)
  );

  always #5 clock = ~clock;

  // Drive one command for exactly one edge; call at posedge+1 with cmd_ready high.
  task automatic issue(input logic [3:0] v, input logic ud, input logic [7:0] l);
    cmd_load_val = v;
    cmd_up_down  = ud;
    cmd_len      = l;
    cmd_valid    = 1'b1;
    @(posedge clock); #1;
    cmd_valid    = 1'b0;
  endtask

  task automatic test_reset;
    #13;                       // mid-cycle, no edge nearby
    reset = 1'b1;
    #1;
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got busy=%b done=%b wrap=%b exp=000", busy, done, wrap); end
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_up_simple;
    logic [3:0] exp_c [0:4];
    exp_c = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd8};
    issue(4'd5, 1'b1, 8'd3);
    n_tests++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL up_accept got busy=%b ready=%b exp busy=1 ready=0", busy, cmd_ready); end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock); #1;
      n_tests++; if (count !== exp_c[k-1]) begin n_fail++; $display("FAIL up_count k=%0d got=%0d exp=%0d", k, count, exp_c[k-1]); end
      n_tests++; if (done !== (k == 4)) begin n_fail++; $display("FAIL up_done k=%0d got=%b exp=%b", k, done, (k == 4)); end
      n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL up_wrap k=%0d got=%b exp=0", k, wrap); end
    end
    n_tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL up_idle got ready=%b busy=%b exp ready=1 busy=0", cmd_ready, busy); end
  endtask

  task automatic test_up_wrap;
    logic [3:0] exp_c [0:4];
    exp_c = '{4'd10, 4'd11, 4'd0, 4'd1, 4'd2};
    issue(4'd10, 1'b1, 8'd4);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock); #1;
      n_tests++; if (count !== exp_c[k-1]) begin n_fail++; $display("FAIL upwrap_count k=%0d got=%0d exp=%0d", k, count, exp_c[k-1]); end
      n_tests++; if (wrap !== (k == 3)) begin n_fail++; $display("FAIL upwrap_wrap k=%0d got=%b exp=%b", k, wrap, (k == 3)); end
      n_tests++; if (done !== (k == 5)) begin n_fail++; $display("FAIL upwrap_done k=%0d got=%b exp=%b", k, done, (k == 5)); end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_down_wrap;
    logic [3:0] exp_c [0:3];
    exp_c = '{4'd1, 4'd0, 4'd11, 4'd10};
    issue(4'd1, 1'b0, 8'd3);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
      n_tests++; if (count !== exp_c[k-1]) begin n_fail++; $display("FAIL down_count k=%0d got=%0d exp=%0d", k, count, exp_c[k-1]); end
      n_tests++; if (wrap !== (k == 3)) begin n_fail++; $display("FAIL down_wrap k=%0d got=%b exp=%b", k, wrap, (k == 3)); end
      n_tests++; if (done !== (k == 4)) begin n_fail++; $display("FAIL down_done k=%0d got=%b exp=%b", k, done, (k == 4)); end
    end
    @(posedge clock); #1;
  endtask

  // Clamp with len 0, then a second command held valid across the first one.
  task automatic test_back_to_back;
    logic [3:0] exp_c [1:6];
    logic       exp_d [1:6];
    logic       exp_r [1:6];
    exp_c = '{4'd11, 4'd11, 4'd11, 4'd2, 4'd1, 4'd1};
    exp_d = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_r = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    cmd_load_val = 4'd14; cmd_up_down = 1'b1; cmd_len = 8'd0; cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_load_val = 4'd2; cmd_up_down = 1'b0; cmd_len = 8'd1;   // still valid
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock); #1;
      if (k == 3) cmd_valid = 1'b0;
      n_tests++; if (count !== exp_c[k]) begin n_fail++; $display("FAIL b2b_count k=%0d got=%0d exp=%0d", k, count, exp_c[k]); end
      n_tests++; if (done !== exp_d[k]) begin n_fail++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, done, exp_d[k]); end
      n_tests++; if (cmd_ready !== exp_r[k]) begin n_fail++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, cmd_ready, exp_r[k]); end
    end
  endtask

  task automatic test_max_len;
    int wraps = 0;
    int done_at = -1;
    issue(4'd0, 1'b1, 8'd255);
    for (int k = 1; k <= 258; k++) begin
      @(posedge clock); #1;
      if (wrap === 1'b1) wraps++;
      if (done === 1'b1 && done_at < 0) done_at = k;
      if (k == 256) begin
        n_tests++; if (count !== 4'd3) begin n_fail++; $display("FAIL maxlen_count got=%0d exp=3", count); end
      end
    end
    n_tests++; if (done_at !== 256) begin n_fail++; $display("FAIL maxlen_done_at got=%0d exp=256", done_at); end
    n_tests++; if (wraps !== 21) begin n_fail++; $display("FAIL maxlen_wraps got=%0d exp=21", wraps); end
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL maxlen_idle got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_reset_mid_run;
    issue(4'd3, 1'b1, 8'd10);
    repeat (4) @(posedge clock);
    #1;
    n_tests++; if (count !== 4'd6) begin n_fail++; $display("FAIL rstrun_pre got=%0d exp=6", count); end
    #3;
    reset = 1'b1;
    #1;
    n_tests++; if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstrun_async got count=%0d busy=%b done=%b ready=%b exp 0 0 0 1", count, busy, done, cmd_ready); end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); #1;
      n_tests++; if (done !== 1'b0 || count !== 4'd0) begin
        n_fail++; $display("FAIL rstrun_after k=%0d got done=%b count=%0d exp 0 0", k, done, count); end
    end
  endtask

`ifdef COUNT_CTRL_PAUSE_EN
  task automatic test_pause;
    logic [3:0] exp_c [1:8];
    exp_c = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4};
    issue(4'd0, 1'b1, 8'd4);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock); #1;
      if (k == 2) pause = 1'b1;
      if (k == 4) pause = 1'b0;
      n_tests++; if (count !== exp_c[k]) begin n_fail++; $display("FAIL pause_count k=%0d got=%0d exp=%0d", k, count, exp_c[k]); end
      n_tests++; if (done !== (k == 7)) begin n_fail++; $display("FAIL pause_done k=%0d got=%b exp=%b", k, done, (k == 7)); end
      n_tests++; if (busy !== (k <= 6)) begin n_fail++; $display("FAIL pause_busy k=%0d got=%b exp=%b", k, busy, (k <= 6)); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_up_simple();
    test_up_wrap();
    test_down_wrap();
    test_back_to_back();
    test_max_len();
`ifdef COUNT_CTRL_PAUSE_EN
    test_pause();
`endif
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
